seq_muldiv: RTL

Iterative 32-bit unsigned multiply/divide unit for the multi-cycle datapath. It sits directly around the 32-bit add/subtract adder and drives it once per cycle: add mode for shift-add multiplication, subtract mode for restoring division. The adder's sum and carry-out are consumed into the HI/LO working registers. Results go to the register-file write-back path through a start/busy/done handshake.

---
 rtl/seq_muldiv_pkg.sv | 18 +
 rtl/seq_muldiv_adder.sv | 21 ++
 rtl/seq_muldiv.sv | 122 ++++++++++++
 3 files changed

// File: rtl/seq_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operand width, iteration count, FSM state encoding and op codes.
package seq_muldiv_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned ITERS = 32;
    localparam int unsigned CNT_W = 5;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_muldiv_adder.sv
// Existing 32-bit add/subtract adder: i_ctr=0 adds, i_ctr=1 computes i_a - i_b.
// o_co is the 33rd bit; in subtract mode it is 1 when no borrow occurred.
import seq_muldiv_pkg::*;

module adder_32bits (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_ctr,
    output logic [WIDTH-1:0] o_s,
    output logic             o_co
);

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;

    assign w_b_eff = i_ctr ? ~i_b : i_b;
    assign w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + (WIDTH+1)'(i_ctr);
    assign o_s     = w_sum[WIDTH-1:0];
    assign o_co    = w_sum[WIDTH];

endmodule

// File: rtl/seq_muldiv.sv
// Iterative 32-bit unsigned multiply (shift-add) / divide (restoring) unit.
// One adder pass per cycle over 32 cycles; result in HI/LO with a done pulse.
import seq_muldiv_pkg::*;

module seq_muldiv (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    state_t           r_state;
    state_t           w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic             r_op;
    logic             w_op_d;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] w_b_d;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] w_hi_d;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] w_lo_d;

    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_add_a;
    logic [WIDTH-1:0] w_sum;
    logic             w_co;
    logic             w_last;

    // Partial remainder for division: HI shifted left, pulling in the next dividend bit.
    assign w_rem   = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
    assign w_add_a = (r_op == OP_DIV) ? w_rem : r_hi;
    assign w_last  = (r_cnt == CNT_W'(ITERS - 1));

    adder_32bits u_adder (
        .i_a   (w_add_a),
        .i_b   (r_b),
        .i_ctr (r_op),
        .o_s   (w_sum),
        .o_co  (w_co)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_op    <= OP_MUL;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_op    <= w_op_d;
            r_b     <= w_b_d;
            r_hi    <= w_hi_d;
            r_lo    <= w_lo_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_op_d    = r_op;
        w_b_d     = r_b;
        w_hi_d    = r_hi;
        w_lo_d    = r_lo;

        unique case (r_state)
            IDLE, DONE: begin
                w_state_d = IDLE;
                if (i_start) begin
                    w_state_d = RUN;
                    w_cnt_d   = '0;
                    w_op_d    = i_op;
                    w_b_d     = i_b;
                    w_hi_d    = '0;
                    w_lo_d    = i_a;
                end
            end
            RUN: begin
                w_cnt_d = r_cnt + CNT_W'(1);
                if (w_last) begin
                    w_state_d = DONE;
                end
                if (r_op == OP_DIV) begin
                    // msb set means the 33-bit remainder already exceeds any divisor.
                    if (r_hi[WIDTH-1] | w_co) begin
                        w_hi_d = w_sum;
                        w_lo_d = {r_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        w_hi_d = w_rem;
                        w_lo_d = {r_lo[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    if (r_lo[0]) begin
                        w_hi_d = {w_co, w_sum[WIDTH-1:1]};
                        w_lo_d = {w_sum[0], r_lo[WIDTH-1:1]};
                    end else begin
                        {w_hi_d, w_lo_d} = {1'b0, r_hi, r_lo[WIDTH-1:1]};
                    end
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    assign o_busy = (r_state == RUN);
    assign o_done = (r_state == DONE);
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule
